rnd_source_hpc3: RTL and testbench

RND_SOURCE_HPC3 -- requirements
Module: rnd_source_hpc3

---
 rtl/rnd_source_hpc3.sv | 125 ++++++++++++
 tb/tb_rnd_source_hpc3.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rnd_source_hpc3.sv
// Seeded 128-bit LFSR randomness source feeding HPC3 gadget r ports, one RW-bit word per handshake.
// Optional repetition health check compiled in with RND_HEALTH_CHECK_EN.
module rnd_source_hpc3 #(
    parameter int security_order = 1,
    parameter int WARMUP = 128,
    localparam int half_rnd = security_order * (security_order + 1) / 2,
    localparam int RW = 2 * half_rnd
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          seed_start,
    input  logic          seed_valid,
    input  logic [31:0]   seed_word,
    output logic [RW-1:0] r,
    output logic          r_valid,
    input  logic          r_ready,
    output logic          busy,
    output logic          err
);
    localparam int CW = $clog2(WARMUP + 1);

    if (RW > 128 || RW < 1) begin : g_rw_check
        $error("rnd_source_hpc3: RW=%0d must be within 1..128", RW);
    end
    if (WARMUP < 1) begin : g_warmup_check
        $error("rnd_source_hpc3: WARMUP must be at least 1");
    end

    typedef enum logic [1:0] {ST_UNSEEDED, ST_SEED, ST_WARMUP, ST_RUN} state_t;

    state_t         state;
    logic [127:0]   s;
    logic [1:0]     wcnt;
    logic [CW-1:0]  ccnt;
    logic [127:0]   s_adv;
    logic [127:0]   s_seed;

    // One advance = RW single LFSR steps, unrolled into one cycle.
    function automatic logic [127:0] advance(input logic [127:0] v);
        logic [127:0] t;
        t = v;
        for (int i = 0; i < RW; i++)
            t = {t[126:0], t[127] ^ t[125] ^ t[100] ^ t[98]};
        return t;
    endfunction

    assign s_adv  = advance(s);
    assign s_seed = {s[95:0], seed_word};

`ifdef RND_HEALTH_CHECK_EN
    logic [2:0] rep;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_UNSEEDED;
            s       <= '0;
            wcnt    <= '0;
            ccnt    <= '0;
            r       <= '0;
            r_valid <= 1'b0;
            busy    <= 1'b0;
`ifdef RND_HEALTH_CHECK_EN
            rep     <= '0;
            err     <= 1'b0;
`endif
        end else if (seed_start) begin
            // A reseed always shifts in four fresh words, so S needs no advance here.
            state   <= ST_SEED;
            wcnt    <= '0;
            ccnt    <= '0;
            r_valid <= 1'b0;
            busy    <= 1'b1;
`ifdef RND_HEALTH_CHECK_EN
            rep     <= '0;
            err     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_SEED: begin
                    if (seed_valid) begin
                        wcnt <= wcnt + 2'd1;
                        if (wcnt == 2'd3) begin
                            // An all-zero LFSR would lock up; force a single set bit.
                            s     <= (s_seed == '0) ? 128'd1 : s_seed;
                            state <= ST_WARMUP;
                        end else begin
                            s <= s_seed;
                        end
                    end
                end
                ST_WARMUP: begin
                    s    <= s_adv;
                    ccnt <= ccnt + CW'(1);
                    if (ccnt == CW'(WARMUP - 1)) begin
                        state   <= ST_RUN;
                        r       <= s_adv[RW-1:0];
                        r_valid <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (r_valid && r_ready) begin
                        s <= s_adv;
                        r <= s_adv[RW-1:0];
`ifdef RND_HEALTH_CHECK_EN
                        if (s_adv[RW-1:0] == r) begin
                            rep <= rep + 3'd1;
                            if (rep == 3'd2) begin
                                err     <= 1'b1;
                                r_valid <= 1'b0;
                            end
                        end else begin
                            rep <= '0;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rnd_source_hpc3.sv
// Scoreboard bench for rnd_source_hpc3: golden LFSR model pushes expected words, popped on each handshake.
module tb_rnd_source_hpc3;
    localparam int SO = 1;
    localparam int WU = 4;
    localparam int HALF = SO * (SO + 1) / 2;
    localparam int RW = 2 * HALF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          seed_start = 1'b0;
    logic          seed_valid = 1'b0;
    logic [31:0]   seed_word = '0;
    logic          r_ready = 1'b0;
    logic [RW-1:0] r;
    logic          r_valid;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    rnd_source_hpc3 #(.security_order(SO), .WARMUP(WU)) dut (
        .clk(clk), .rst_n(rst_n), .seed_start(seed_start), .seed_valid(seed_valid),
        .seed_word(seed_word), .r(r), .r_valid(r_valid), .r_ready(r_ready),
        .busy(busy), .err(err)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [127:0]  m_s;
    logic [RW-1:0] q[$];
    logic [RW-1:0] m_prev;
    int            m_rep;
    bit            m_run;
    bit            m_err;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [127:0] lfsr_step(input logic [127:0] v);
        return {v[126:0], v[127] ^ v[125] ^ v[100] ^ v[98]};
    endfunction

    function automatic logic [127:0] m_adv(input logic [127:0] v);
        logic [127:0] t;
        t = v;
        for (int i = 0; i < RW; i++) t = lfsr_step(t);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seed_in(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        seed_start = 1'b1;
        tick();
        seed_start = 1'b0;
        m_run = 0; m_err = 0; m_rep = 0; q.delete();
        check("busy_after_start", busy, 1);
        check("rv_after_start", r_valid, 0);
        for (int i = 0; i < 4; i++) begin
            seed_valid = 1'b1;
            seed_word  = w[i];
            tick();
            check("busy_seed", busy, 1);
            check("rv_seed", r_valid, 0);
        end
        seed_valid = 1'b0;
        m_s = {w0, w1, w2, w3};
        if (m_s == '0) m_s = 128'd1;
        for (int i = 0; i < WU; i++) begin
            m_s = m_adv(m_s);
            tick();
            if (i < WU - 1) check("busy_warmup", busy, 1);
        end
        check("busy_run", busy, 0);
        q.push_back(m_s[RW-1:0]);
        m_prev = m_s[RW-1:0];
        m_run  = 1;
    endtask

    // One RUN-phase cycle: check outputs against the model, then drive rdy/ss across the edge.
    task automatic cyc(input bit rdy, input bit ss);
        bit            exp_v;
        logic [RW-1:0] nw;
        exp_v = m_run && !m_err;
        check("r_valid", r_valid, exp_v);
        check("err", err, m_err);
        if (exp_v) check("r_word", r, q[0]);
        r_ready    = rdy;
        seed_start = ss;
        if (exp_v && rdy) begin
            void'(q.pop_front());
            m_s = m_adv(m_s);
            nw  = m_s[RW-1:0];
`ifdef RND_HEALTH_CHECK_EN
            if (nw == m_prev) begin
                m_rep++;
                if (m_rep == 3) m_err = 1;
            end else begin
                m_rep = 0;
            end
`endif
            q.push_back(nw);
            m_prev = nw;
        end
        tick();
        r_ready    = 1'b0;
        seed_start = 1'b0;
        if (ss) begin
            m_run = 0; m_err = 0; m_rep = 0; q.delete();
            check("rv_after_reseed", r_valid, 0);
            check("busy_after_reseed", busy, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_nz;
        bit pat [5];
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1;
        m_run = 0; m_err = 0; m_rep = 0;

        // reset state
        tick(); tick();
        check("rst_r", r, 0);
        check("rst_rv", r_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick();
        // UNSEEDED ignores seed words without seed_start
        seed_valid = 1'b1; seed_word = 32'hFFFF_FFFF;
        tick();
        seed_valid = 1'b0;
        check("unseeded_busy", busy, 0);
        check("unseeded_rv", r_valid, 0);

        // seed 0,0,0,1: S=1 then 4 advances gives S=1<<8, first word is 0
        seed_in(32'h0, 32'h0, 32'h0, 32'h1);
        check("golden_first", r, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0);

        // r_ready toggling: r must hold while not ready, no word skipped
        seed_in(32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_BABE, 32'h0F0F_1234);
        for (int i = 0; i < 5; i++) cyc(pat[i], 0);
        for (int i = 0; i < 24; i++) cyc(1'($urandom_range(0, 1)), 0);

        // reseed during RUN with a simultaneous handshake
        cyc(1, 1);

        // all-zero seed is rescued and eventually yields non-zero words
        seed_in(32'h0, 32'h0, 32'h0, 32'h0);
        seen_nz = 0;
        for (int i = 0; i < 60; i++) begin
            if (r_valid && r != '0) seen_nz = 1;
            cyc(1, 0);
        end
`ifndef RND_HEALTH_CHECK_EN
        check("zero_seed_not_stuck", seen_nz, 1);
`endif

        // reset held 3 cycles in the middle of WARMUP
        seed_start = 1'b1; tick(); seed_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seed_valid = 1'b1; seed_word = 32'hA5A5_0000 + 32'(i); tick();
        end
        seed_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midwarm_rst_busy", busy, 0);
        check("midwarm_rst_rv", r_valid, 0);
        check("midwarm_rst_r", r, 0);
        check("midwarm_rst_err", err, 0);
        tick(); tick(); tick();
        rst_n = 1'b1;
        m_run = 0; m_err = 0; m_rep = 0; q.delete();
        for (int i = 0; i < WU + 2; i++) begin
            tick();
            check("post_rst_busy", busy, 0);
            check("post_rst_rv", r_valid, 0);
        end

        // recovery after reset
        seed_in(32'h0BAD_F00D, 32'h7777_1111, 32'h2468_ACE0, 32'h1357_9BDF);
        for (int i = 0; i < 8; i++) cyc(1, 0);

`ifdef RND_HEALTH_CHECK_EN
        // freeze S so every advance repeats the same word
        seed_in(32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888);
        force dut.s = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
        for (int i = 0; i < 8; i++) begin
            if (!err) begin
                r_ready = 1'b1;
                tick();
            end
        end
        r_ready = 1'b0;
        check("hc_err_set", err, 1);
        check("hc_rv_low", r_valid, 0);
        release dut.s;
        seed_start = 1'b1; tick(); seed_start = 1'b0;
        check("hc_err_cleared", err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
